// File: rtl/tap_ctrl.sv
// tap_ctrl: IEEE 1149.1 TAP controller (16-state FSM, IR, DR strobes, TDO mux).
// Ports: TCK/TRST clock + async active-low reset; TMS/TDI/TDO/TDO_en pins;
//   tlr_reset/CaptureDR/ShiftDR/UpdateDR strobes; bpr_select/ext_select DR selects;
//   bpr_tdo/ext_tdo serial DR returns; ir_out latched instruction.
// Option: define TAP_IDCODE_EN to add an internal 32-bit IDCODE DR.
module tap_ctrl #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] BYPASS_OP  = '1,
  parameter logic [IR_WIDTH-1:0] EXT_OP     = IR_WIDTH'(4'b0010),
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(4'b0001),
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_en,
  output logic                tlr_reset,
  output logic                CaptureDR,
  output logic                ShiftDR,
  output logic                UpdateDR,
  output logic                bpr_select,
  output logic                ext_select,
  input  logic                bpr_tdo,
  input  logic                ext_tdo,
  output logic [IR_WIDTH-1:0] ir_out
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI,
    S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR,
    S_PAUSE_DR, S_EXIT2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR,
    S_PAUSE_IR, S_EXIT2_IR, S_UPD_IR
  } state_t;

`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RST_OP = IDCODE_OP;
`else
  localparam logic [IR_WIDTH-1:0] RST_OP = BYPASS_OP;
`endif

  state_t              r_state;
  state_t              w_next;
  logic                r_tlr;
  logic                r_cap;
  logic                r_shift;
  logic                r_upd;
  logic [IR_WIDTH-1:0] r_ir_sh;
  logic [IR_WIDTH-1:0] r_ir;
  logic                r_tdo;
  logic                r_tdo_en;
  logic                w_ext_sel;
  logic                w_id_sel;
  logic                w_dr_tdo;

  always_comb begin
    w_next = S_TLR;
    unique case (r_state)
      S_TLR:      w_next = TMS ? S_TLR      : S_RTI;
      S_RTI:      w_next = TMS ? S_SEL_DR   : S_RTI;
      S_SEL_DR:   w_next = TMS ? S_SEL_IR   : S_CAP_DR;
      S_CAP_DR:   w_next = TMS ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR: w_next = TMS ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR: w_next = TMS ? S_UPD_DR   : S_PAUSE_DR;
      S_PAUSE_DR: w_next = TMS ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR: w_next = TMS ? S_UPD_DR   : S_SHIFT_DR;
      S_UPD_DR:   w_next = TMS ? S_SEL_DR   : S_RTI;
      S_SEL_IR:   w_next = TMS ? S_TLR      : S_CAP_IR;
      S_CAP_IR:   w_next = TMS ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR: w_next = TMS ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR: w_next = TMS ? S_UPD_IR   : S_PAUSE_IR;
      S_PAUSE_IR: w_next = TMS ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR: w_next = TMS ? S_UPD_IR   : S_SHIFT_IR;
      S_UPD_IR:   w_next = TMS ? S_SEL_DR   : S_RTI;
      default:    w_next = S_TLR;
    endcase
  end

  // Strobes are registered from the next state so they track r_state exactly.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_state <= S_TLR;
      r_tlr   <= 1'b1;
      r_cap   <= 1'b0;
      r_shift <= 1'b0;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tlr   <= (w_next == S_TLR);
      r_cap   <= (w_next == S_CAP_DR);
      r_shift <= (w_next == S_SHIFT_DR);
      r_upd   <= (w_next == S_UPD_DR);
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_ir_sh <= '0;
      r_ir    <= RST_OP;
    end else begin
      case (r_state)
        S_TLR:      r_ir    <= RST_OP;
        S_CAP_IR:   r_ir_sh <= IR_WIDTH'(2'b01);
        S_SHIFT_IR: r_ir_sh <= {TDI, r_ir_sh[IR_WIDTH-1:1]};
        S_UPD_IR:   r_ir    <= r_ir_sh;
        default:    ;
      endcase
    end
  end

  assign w_ext_sel = (r_ir == EXT_OP);

`ifdef TAP_IDCODE_EN
  logic [31:0] r_id;

  assign w_id_sel = (r_ir == IDCODE_OP) && !w_ext_sel;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_id <= '0;
    end else if (w_id_sel) begin
      if (r_state == S_CAP_DR) begin
        r_id <= IDCODE_VAL;
      end else if (r_state == S_SHIFT_DR) begin
        r_id <= {TDI, r_id[31:1]};
      end
    end
  end
`else
  logic w_unused_id;

  assign w_id_sel    = 1'b0;
  assign w_unused_id = ^{IDCODE_OP, IDCODE_VAL};
`endif

  always_comb begin
    w_dr_tdo = bpr_tdo;
    unique case (1'b1)
      w_ext_sel: w_dr_tdo = ext_tdo;
`ifdef TAP_IDCODE_EN
      w_id_sel:  w_dr_tdo = r_id[0];
`endif
      default:   w_dr_tdo = bpr_tdo;
    endcase
  end

  // TDO changes on the falling edge so the pin is stable at the next rise.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (r_state == S_SHIFT_IR) begin
      r_tdo    <= r_ir_sh[0];
      r_tdo_en <= 1'b1;
    end else if (r_state == S_SHIFT_DR) begin
      r_tdo    <= w_dr_tdo;
      r_tdo_en <= 1'b1;
    end else begin
      r_tdo_en <= 1'b0;
    end
  end

  assign TDO        = r_tdo;
  assign TDO_en     = r_tdo_en;
  assign tlr_reset  = r_tlr;
  assign CaptureDR  = r_cap;
  assign ShiftDR    = r_shift;
  assign UpdateDR   = r_upd;
  assign ext_select = w_ext_sel;
  assign bpr_select = !w_ext_sel && !w_id_sel;
  assign ir_out     = r_ir;

endmodule
